// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus arbiter: FSM state encoding and the
// 2-bit transfer size codes used on both the master and memory sides.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_e;

   localparam logic [1:0] SZ_NONE = 2'b00;
   localparam logic [1:0] SZ_BYTE = 2'b01;
   localparam logic [1:0] SZ_HALF = 2'b10;
   localparam logic [1:0] SZ_WORD = 2'b11;

   // A transfer carrying both codes is a write; the read code is dropped.
   function automatic logic [1:0] eff_read(input logic [1:0] rd, input logic [1:0] wr);
      return (wr != SZ_NONE) ? SZ_NONE : rd;
   endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: the first eligible requester found
// searching upward from last_grant+1 (modulo N) wins; output is one-hot.
module rr_select #(
   parameter int unsigned N  = 2,
   parameter int unsigned IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] last_grant,
   output logic [N-1:0]  gnt
);

   logic [N-1:0] elig;
   logic         found;

   assign elig = req & mask;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= N; k++) begin
         for (int unsigned j = 0; j < N; j++) begin
            if (!found && elig[j] && (j == (32'(last_grant) + k) % N)) begin
               gnt[j] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Multi-master memory bus arbiter: round-robin grant with optional bus lock,
// single outstanding memory access, ack/err completion and access timeout.
module memory_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int unsigned N_MASTERS = 2,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_MASTERS-1:0]          m_req,
   input  logic [N_MASTERS-1:0]          m_lock,
   input  logic [2*N_MASTERS-1:0]        m_mem_read,
   input  logic [2*N_MASTERS-1:0]        m_mem_write,
   input  logic [ADDR_W*N_MASTERS-1:0]   m_address,
   input  logic [DATA_W*N_MASTERS-1:0]   m_word_in,
   output logic [N_MASTERS-1:0]          grant,
   output logic [N_MASTERS-1:0]          m_ack,
   output logic [N_MASTERS-1:0]          m_err,
   output logic [DATA_W-1:0]             m_word_out,
   output logic [1:0]                    mem_read,
   output logic [1:0]                    mem_write,
   output logic [ADDR_W-1:0]             address,
   output logic [DATA_W-1:0]             word_in,
   input  logic [DATA_W-1:0]             mem_word_out,
   input  logic                          mem_ready
);

   localparam int unsigned IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int unsigned CW = 16;

   state_e                state_q, state_d;
   logic [N_MASTERS-1:0]  grant_q, grant_d;
   logic [N_MASTERS-1:0]  ack_q, ack_d;
   logic [N_MASTERS-1:0]  err_q, err_d;
   logic [N_MASTERS-1:0]  lock_mask_q, lock_mask_d;
   logic                  lock_q, lock_d;
   logic [IW-1:0]         last_grant_q, last_grant_d;
   logic [1:0]            mem_read_q, mem_read_d;
   logic [1:0]            mem_write_q, mem_write_d;
   logic [ADDR_W-1:0]     address_q, address_d;
   logic [DATA_W-1:0]     word_in_q, word_in_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic [N_MASTERS-1:0]  mask;
   logic [N_MASTERS-1:0]  win;
   logic [IW-1:0]         owner_idx;
   logic [1:0]            win_rd, win_wr;
   logic [ADDR_W-1:0]     win_addr;
   logic [DATA_W-1:0]     win_data;

   // While locked only the lock owner may win arbitration.
   assign mask = lock_q ? lock_mask_q : '1;

   rr_select #(
      .N  (N_MASTERS),
      .IW (IW)
   ) u_rr_select (
      .req        (m_req),
      .mask       (mask),
      .last_grant (last_grant_q),
      .gnt        (win)
   );

   always_comb begin
      win_rd   = SZ_NONE;
      win_wr   = SZ_NONE;
      win_addr = '0;
      win_data = '0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         if (win[i]) begin
            win_rd   = m_mem_read[2*i +: 2];
            win_wr   = m_mem_write[2*i +: 2];
            win_addr = m_address[ADDR_W*i +: ADDR_W];
            win_data = m_word_in[DATA_W*i +: DATA_W];
         end
      end
   end

   always_comb begin
      owner_idx = '0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         if (grant_q[i]) owner_idx = IW'(i);
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      ack_d        = '0;
      err_d        = '0;
      lock_d       = lock_q;
      lock_mask_d  = lock_mask_q;
      last_grant_d = last_grant_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      address_d    = address_q;
      word_in_d    = word_in_q;
      rdata_d      = rdata_q;
      cnt_d        = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (|win) begin
               state_d     = ACCESS;
               grant_d     = win;
               mem_read_d  = eff_read(win_rd, win_wr);
               mem_write_d = win_wr;
               address_d   = win_addr;
               word_in_d   = win_data;
               cnt_d       = '0;
            end
         end
         ACCESS: begin
            // mem_ready takes priority over a timeout landing on the same edge.
            if (mem_ready) begin
               state_d = RESP;
               ack_d   = grant_q;
               if (mem_read_q != SZ_NONE) rdata_d = mem_word_out;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = RESP;
               err_d   = grant_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            state_d      = IDLE;
            grant_d      = '0;
            mem_read_d   = SZ_NONE;
            mem_write_d  = SZ_NONE;
            last_grant_d = owner_idx;
            if ((|(m_lock & grant_q)) && !(|err_q)) begin
               lock_d      = 1'b1;
               lock_mask_d = grant_q;
            end else begin
               lock_d      = 1'b0;
               lock_mask_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         ack_q        <= '0;
         err_q        <= '0;
         lock_q       <= 1'b0;
         lock_mask_q  <= '0;
         last_grant_q <= IW'(N_MASTERS - 1);
         mem_read_q   <= SZ_NONE;
         mem_write_q  <= SZ_NONE;
         address_q    <= '0;
         word_in_q    <= '0;
         rdata_q      <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         lock_q       <= lock_d;
         lock_mask_q  <= lock_mask_d;
         last_grant_q <= last_grant_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         address_q    <= address_d;
         word_in_q    <= word_in_d;
         rdata_q      <= rdata_d;
         cnt_q        <= cnt_d;
      end
   end

   assign grant      = grant_q;
   assign m_ack      = ack_q;
   assign m_err      = err_q;
   assign m_word_out = rdata_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign address    = address_q;
   assign word_in    = word_in_q;

endmodule
